ysyx_24100005_wbu: RTL

YSYX_24100005_WBU -- requirements
Module: ysyx_24100005_wbu

---
 rtl/ysyx_24100005_wbu_if.sv | 29 ++
 rtl/ysyx_24100005_wbu.sv | 119 +++++++++++
 2 files changed

// File: rtl/ysyx_24100005_wbu_if.sv
// Result channel from EXU/LSU into the writeback unit.
interface ysyx_24100005_wbu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_rd_wen;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [DATA_WIDTH-1:0] in_data;

  // Producer side (EXU/LSU)
  modport master (
    output in_valid,
    output in_rd_wen,
    output in_rd,
    output in_data,
    input  in_ready
  );

  // Consumer side (WBU)
  modport slave (
    input  in_valid,
    input  in_rd_wen,
    input  in_rd,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/ysyx_24100005_wbu.sv
// Writeback unit: a 2-entry result FIFO that retires one result per cycle
// into the register file, counts the retired results, and optionally keeps a
// per-register pending-write scoreboard for decode.
// The scoreboard is built only when YSYX_24100005_WBU_SCOREBOARD_EN is defined.
module ysyx_24100005_wbu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24100005_wbu_if.slave    in_bus,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [31:0]           retire_cnt,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  q_rs1_busy,
  output logic                  q_rs2_busy
);

  localparam int unsigned DEPTH = 2;

  logic                  r_wen_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_q [DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic [31:0]           r_retire_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_not_full;
  logic                  w_head_wen;
  logic [ADDR_WIDTH-1:0] w_head_rd;

  // Handshake and head view, all from registered state
  assign w_not_full       = (r_count != 2'd2);
  assign in_bus.in_ready  = w_not_full;
  assign w_push           = in_bus.in_valid && w_not_full;
  assign w_pop            = (r_count != 2'd0);
  assign w_head_wen       = r_wen_q[r_rptr];
  assign w_head_rd        = r_rd_q[r_rptr];

  assign commit_valid = w_pop;
  assign rf_wen       = w_pop && w_head_wen && (w_head_rd != '0);
  assign rf_waddr     = w_head_rd;
  assign rf_wdata     = r_data_q[r_rptr];
  assign retire_cnt   = r_retire_cnt;

  // FIFO storage, pointers, occupancy and retirement counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_wen_q[i]  <= 1'b0;
        r_rd_q[i]   <= '0;
        r_data_q[i] <= '0;
      end
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= 2'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (w_push) begin
        r_wen_q[r_wptr]  <= in_bus.in_rd_wen;
        r_rd_q[r_wptr]   <= in_bus.in_rd;
        r_data_q[r_wptr] <= in_bus.in_data;
        r_wptr           <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr       <= ~r_rptr;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

`ifdef YSYX_24100005_WBU_SCOREBOARD_EN
  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Clear on retiring write, then set on issue so a same-cycle set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop && w_head_wen) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end
    if (iss_valid) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy bit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign q_rs1_busy = r_busy[q_rs1];
  assign q_rs2_busy = r_busy[q_rs2];
`else
  logic w_unused;

  assign w_unused   = ^{iss_valid, iss_rd, q_rs1, q_rs2};
  assign q_rs1_busy = 1'b0;
  assign q_rs2_busy = 1'b0;
`endif

endmodule
